// File: rtl/nibble_serial_adder_ctrl.sv
// ============================================================================
// Module   : nibble_serial_adder_ctrl (with CLA_4bit slice)
// Purpose  : WIDTH-bit add/sub computed nibble-serially on one shared 4-bit CLA.
// Options  : define NSA_SUB_EN to add the 'sub' port (A - B via ~B + 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module CLA_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout,
    output logic       Xout,
    output logic       Yout
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = A ^ B;
    assign w_g = A & B;

    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);

    // Group propagate / generate, so the slice can also sit in a two-level CLA tree
    assign Xout = &w_p;
    assign Yout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign Sum  = w_p ^ w_c;
    assign Cout = Yout | (Xout & Cin);
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int c_N     = WIDTH / 4;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_q;
    logic [WIDTH-1:0]   r_b_q;
    logic [WIDTH-1:0]   r_sum_q;
    logic               r_c_q;
    logic [c_IDX_W-1:0] r_idx;

    logic [WIDTH-1:0]   w_b_eff;
    logic               w_c_init;
    logic [3:0]         w_slice_a;
    logic [3:0]         w_slice_b;
    logic [3:0]         w_slice_sum;
    logic               w_slice_cout;
    logic               w_slice_x;
    logic               w_slice_y;

`ifdef NSA_SUB_EN
    assign w_b_eff  = sub ? ~b_in : b_in;
    assign w_c_init = sub | cin;
`else
    assign w_b_eff  = b_in;
    assign w_c_init = cin;
`endif

    assign w_slice_a = r_a_q[4*r_idx +: 4];
    assign w_slice_b = r_b_q[4*r_idx +: 4];

    CLA_4bit u_slice (
        .A    (w_slice_a),
        .B    (w_slice_b),
        .Cin  (r_c_q),
        .Sum  (w_slice_sum),
        .Cout (w_slice_cout),
        .Xout (w_slice_x),
        .Yout (w_slice_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_q   <= '0;
            r_b_q   <= '0;
            r_sum_q <= '0;
            r_c_q   <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a_q   <= a_in;
                        r_b_q   <= w_b_eff;
                        r_c_q   <= w_c_init;
                        r_sum_q <= '0;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum_q[4*r_idx +: 4] <= w_slice_sum;
                    r_c_q                 <= w_slice_cout;
                    if (r_idx != c_IDX_LAST) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        start_ready  = 1'b0;
        busy         = 1'b0;
        res_valid    = 1'b0;
        sum          = '0;
        cout         = 1'b0;
        ovf          = 1'b0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_idx == c_IDX_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                sum       = r_sum_q;
                cout      = r_c_q;
                // Overflow uses the effective B, so it is correct for subtraction too
                ovf       = (r_a_q[WIDTH-1] == r_b_q[WIDTH-1])
                          && (r_sum_q[WIDTH-1] != r_a_q[WIDTH-1]);
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Purpose  : Scoreboard bench for nibble_serial_adder_ctrl, WIDTH = 16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        cin;
    logic        sub_r;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   prev_rv = 1'b0;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin         (cin),
`ifdef NSA_SUB_EN
        .sub         (sub_r),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event occurred, required none (cycle %0d)", nm, cyc);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each result handshake
    always @(negedge clk) begin
        exp_t e;
        int   t;
        if (rst_n) begin
            if (start_valid && start_ready) acc_q.push_back(cyc + 1);
            if (res_valid && !prev_rv) begin
                if (acc_q.size() == 0) flag("stray_res_valid");
                else begin
                    t = acc_q.pop_front();
                    chk("latency", 32'(cyc - t), 32'd4);
                end
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) flag("unexpected_result");
                else begin
                    e = exp_q.pop_front();
                    chk("sum", {16'h0, sum}, {16'h0, e.s});
                    chk("cout", {31'h0, cout}, {31'h0, e.c});
                    chk("ovf", {31'h0, ovf}, {31'h0, e.o});
                end
            end
            if (!res_valid) chk("outputs_zero_outside_done", {14'h0, sum, cout, ovf}, 32'h0);
            prev_rv = res_valid;
        end else begin
            prev_rv = 1'b0;
        end
    end

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (start_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("accept_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic s, input logic [15:0] es, input logic ec,
                         input logic eo, input bit hold);
        exp_t e;
        e.s = es; e.c = ec; e.o = eo;
        exp_q.push_back(e);
        a_in = a; b_in = b; cin = ci; sub_r = s; start_valid = 1'b1;
        wait_accept();
        // Operands must have been captured at accept; scramble them afterwards
        a_in = 16'hDEAD; b_in = 16'hBEEF; cin = ~ci; sub_r = ~s;
        if (hold) begin
            repeat (5) begin
                @(posedge clk);
                #1;
            end
        end
        start_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) flag("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        sub_r = 1'b0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ready", {31'h0, start_ready}, 32'd1);
        chk("rst_res_valid", {31'h0, res_valid}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_outputs", {14'h0, sum, cout, ovf}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_op(16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // Backpressure: result must hold while res_ready is low
        res_ready = 1'b0;
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        chk("busy_in_run", {31'h0, busy}, 32'd1);
        for (int i = 0; i < 40 && !res_valid; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            start_valid = (i == 1);
            @(negedge clk);
            chk("bp_res_valid", {31'h0, res_valid}, 32'd1);
            chk("bp_sum_stable", {16'h0, sum}, 32'h1000);
            chk("bp_start_ready", {31'h0, start_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_start_ready", {31'h0, start_ready}, 32'd1);
        chk("bp_idle_res_valid", {31'h0, res_valid}, 32'd0);
        wait_drain();

        // Reset in the middle of RUN discards the operation
        a_in = 16'hAAAA; b_in = 16'h5555; cin = 1'b0; sub_r = 1'b0; start_valid = 1'b1;
        wait_accept();
        start_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_res_valid", {31'h0, res_valid}, 32'd0);
        chk("midrst_sum", {16'h0, sum}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'd0);
        acc_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_start_ready", {31'h0, start_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;

        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
`ifdef NSA_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
`endif
        wait_drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
